// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
// Shared types and constants for the stream mux/demux family.
//   state_t          : arbiter FSM state encoding (IDLE / LOCK0 / LOCK1)
//   DEFAULT_DATA_W   : default payload width for stream blocks
// ---------------------------------------------------------------------------
package stream_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

endpackage : stream_pkg

// File: rtl/stream_out_reg.sv
// ---------------------------------------------------------------------------
// stream_out_reg
// Single-entry registered output stage with a valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_load              : load a new beat this edge (caller only asserts it
//                         when o_can_load is high)
//   i_data/i_last/i_src : beat contents to load
//   i_m_ready           : downstream sink ready
//   o_valid/o_data/o_last/o_src : registered output beat
//   o_can_load          : the stage is empty or draining this cycle
//
// Handshake: a beat moves on a rising edge where valid and ready are both 1.
// o_can_load depends only on the register contents and i_m_ready, never on
// the upstream valid, so load and drain may coincide for 1 beat/clk.
// ---------------------------------------------------------------------------
module stream_out_reg
  import stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_src,
  input  logic              i_m_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_src,
  output logic              o_can_load
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_src;

  assign o_can_load = !r_valid || i_m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_src   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
      r_src   <= i_src;
    end else if (r_valid && i_m_ready) begin
      // Drained with nothing behind it; payload fields keep their last value.
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_src   = r_src;

endmodule : stream_out_reg

// File: rtl/stream_mux_2x1_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_2x1_rr
// Merges two packet streams onto one channel. Round-robin arbitration with
// the grant locked from the first beat of a packet until its last=1 beat.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   s0_valid/s0_ready/s0_data/s0_last   : input stream 0
//   s1_valid/s1_ready/s1_data/s1_last   : input stream 1
//   m_valid/m_ready/m_data/m_last/m_src : merged output stream; m_src is the
//                                         input that supplied the beat
//   dbg_state, dbg_prio                 : arbiter state and round-robin
//                                         pointer, for observation only
//
// Handshake: a transfer occurs on a rising edge where valid and ready are both
// 1; sources hold valid/data/last stable until accepted; no ready depends
// combinationally on its own port's valid.
//
// Every packet spends one cycle in IDLE before its lock, so consecutive
// packets are separated by exactly one bubble on the output.
// ---------------------------------------------------------------------------
module stream_mux_2x1_rr
  import stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_src,
  output state_t            dbg_state,
  output logic              dbg_prio
);

  state_t            r_state;
  logic              r_prio;

  logic              w_can_load;
  logic              w_fire0;
  logic              w_fire1;
  logic              w_load;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_ld_last;
  logic              w_ld_src;

  // Only the locked input sees ready, and only when the output stage has room.
  assign s0_ready = (r_state == LOCK0) && w_can_load;
  assign s1_ready = (r_state == LOCK1) && w_can_load;

  assign w_fire0   = s0_valid && s0_ready;
  assign w_fire1   = s1_valid && s1_ready;
  assign w_load    = w_fire0 || w_fire1;
  assign w_ld_data = w_fire1 ? s1_data : s0_data;
  assign w_ld_last = w_fire1 ? s1_last : s0_last;
  assign w_ld_src  = w_fire1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s0_valid && s1_valid) begin
            r_state <= r_prio ? LOCK1 : LOCK0;
          end else if (s0_valid) begin
            r_state <= LOCK0;
          end else if (s1_valid) begin
            r_state <= LOCK1;
          end
        end
        LOCK0: begin
          // The lock holds across source stalls; only a last beat releases it.
          if (w_fire0 && s0_last) begin
            r_state <= IDLE;
            r_prio  <= 1'b1;
          end
        end
        LOCK1: begin
          if (w_fire1 && s1_last) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  stream_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_data     (w_ld_data),
    .i_last     (w_ld_last),
    .i_src      (w_ld_src),
    .i_m_ready  (m_ready),
    .o_valid    (m_valid),
    .o_data     (m_data),
    .o_last     (m_last),
    .o_src      (m_src),
    .o_can_load (w_can_load)
  );

  assign dbg_state = r_state;
  assign dbg_prio  = r_prio;

endmodule : stream_mux_2x1_rr
